// File: rtl/nios_led_cpu_oci_dct_packer.sv
// nios_led_cpu_oci_dct_packer
//
// Debug-trace capture stage for the OCI test bench. It packs 3-bit trace codes
// into a 10-slot, 30-bit buffer and exposes the live buffer on dct_buffer and
// dct_count. Full or partial buffers move into a frame holding register that is
// handed downstream over a valid/ready handshake. It also runs the end-of-test
// sequence RUN -> FLUSH -> DRAIN -> ENDED.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   trc_valid/_code    trace code offered; trc_ready accepts it
//   stop_req           end-of-test request (level or pulse)
//   dct_buffer/_count  live packing buffer (newest code in [2:0]) and slot count
//   frame_valid/_data/_count/_ready  downstream frame handshake
//   test_ending        sticky; set on entering FLUSH
//   test_has_ended     sticky; set on entering ENDED
//   stall_cnt          cycles with trc_valid && !trc_ready (saturating)
//
// Optional feature: define DCT_STALL_COUNTER_EN to build the stall counter.
// Without it stall_cnt is tied to zero.

module nios_led_cpu_oci_dct_packer #(
  parameter int unsigned SLOT_W = 3,
  parameter int unsigned SLOTS  = 10,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      trc_valid,
  input  logic [SLOT_W-1:0]         trc_code,
  output logic                      trc_ready,
  input  logic                      stop_req,
  output logic [SLOT_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      frame_valid,
  output logic [SLOT_W*SLOTS-1:0]   frame_data,
  output logic [CNT_W-1:0]          frame_count,
  input  logic                      frame_ready,
  output logic                      test_ending,
  output logic                      test_has_ended,
  output logic [15:0]               stall_cnt
);

  localparam int unsigned BufW = SLOT_W * SLOTS;

  typedef enum logic [1:0] {StRun, StFlush, StDrain, StEnded} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [BufW-1:0]       r_buf;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_fvalid;
  logic [BufW-1:0]       r_fdata;
  logic [CNT_W-1:0]      r_fcount;
  logic                  r_ending;
  logic                  r_ended;

  logic                  w_full;
  logic                  w_accept;
  logic                  w_flush_xfer;
  logic                  w_transfer;

  always_comb begin
    w_full       = (r_cnt == CNT_W'(SLOTS));
    // Depends only on registered state, so no path from frame_ready.
    trc_ready    = (r_state == StRun) && (!w_full || !r_fvalid);
    w_accept     = trc_valid && trc_ready;
    w_flush_xfer = (r_state == StFlush) && (r_cnt != '0) && !r_fvalid;
    w_transfer   = (w_full && !r_fvalid) || w_flush_xfer;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   if (stop_req) w_state_next = StFlush;
      StFlush: if ((r_cnt == '0) || w_flush_xfer) w_state_next = StDrain;
      StDrain: if (!r_fvalid) w_state_next = StEnded;
      StEnded: w_state_next = StEnded;
      default: w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StRun;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_fvalid <= 1'b0;
      r_fdata  <= '0;
      r_fcount <= '0;
      r_ending <= 1'b0;
      r_ended  <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_transfer) begin
        r_fdata  <= r_buf;
        r_fcount <= r_cnt;
        // A same-cycle accept lands in the freshly cleared buffer.
        if (w_accept) begin
          r_buf <= {{(BufW-SLOT_W){1'b0}}, trc_code};
          r_cnt <= CNT_W'(1);
        end else begin
          r_buf <= '0;
          r_cnt <= '0;
        end
      end else if (w_accept) begin
        r_buf <= {r_buf[BufW-SLOT_W-1:0], trc_code};
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A new transfer overrides a consume in the same cycle.
      if (w_transfer) begin
        r_fvalid <= 1'b1;
      end else if (r_fvalid && frame_ready) begin
        r_fvalid <= 1'b0;
      end

      if ((r_state == StRun) && (w_state_next == StFlush)) r_ending <= 1'b1;
      if ((r_state != StEnded) && (w_state_next == StEnded)) r_ended <= 1'b1;
    end
  end

`ifdef DCT_STALL_COUNTER_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (trc_valid && !trc_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign frame_valid    = r_fvalid;
  assign frame_data     = r_fdata;
  assign frame_count    = r_fcount;
  assign test_ending    = r_ending;
  assign test_has_ended = r_ended;

endmodule

// File: tb/tb_nios_led_cpu_oci_dct_packer.sv
// Bench for nios_led_cpu_oci_dct_packer: a queue-based model of the trace
// buffer and frame register is stepped once per clock; a negedge process
// compares every output against it. Directed literal checks pin the model.

module tb_nios_led_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trc_valid = 1'b0;
  logic [2:0]  trc_code = 3'd0;
  logic        stop_req = 1'b0;
  logic        frame_ready = 1'b0;
  logic        trc_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  nios_led_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trc_valid      (trc_valid),
    .trc_code       (trc_code),
    .trc_ready      (trc_ready),
    .stop_req       (stop_req),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .frame_ready    (frame_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .stall_cnt      (stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: codes in arrival order, frame contents, phase 0=run 1=flush 2=drain 3=ended.
  int m_q[$];
  int m_f[$];
  bit m_fv = 1'b0;
  int m_ph = 0;
  bit m_ending = 1'b0;
  bit m_ended = 1'b0;
  int m_stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (m_ph == 0) && ((m_q.size() < 10) || !m_fv);
  endfunction

  function automatic logic [31:0] m_buf_val();
    logic [31:0] v = 0;
    foreach (m_q[i]) v = v * 8 + m_q[i];
    return v;
  endfunction

  function automatic logic [31:0] m_frame_val();
    logic [31:0] v = 0;
    foreach (m_f[i]) v = v * 8 + m_f[i];
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_f.delete();
    m_fv = 0;
    m_ph = 0;
    m_ending = 0;
    m_ended = 0;
    m_stalls = 0;
  endtask

  task automatic model_step();
    bit rdy = m_ready();
    bit acc = trc_valid && rdy;
    bit send = !m_fv && (m_q.size() > 0) && ((m_q.size() == 10) || (m_ph == 1));
    int nph = m_ph;
`ifdef DCT_STALL_COUNTER_EN
    if (trc_valid && !rdy && (m_stalls < 65535)) m_stalls++;
`endif
    case (m_ph)
      0: if (stop_req) nph = 1;
      1: if ((m_q.size() == 0) || send) nph = 2;
      2: if (!m_fv) nph = 3;
      default: nph = m_ph;
    endcase
    if (m_fv && frame_ready) m_fv = 0;
    if (send) begin
      m_f = m_q;
      m_fv = 1;
      m_q.delete();
    end
    if (acc) m_q.push_back(int'(trc_code));
    if ((m_ph == 0) && (nph == 1)) m_ending = 1;
    if ((m_ph != 3) && (nph == 3)) m_ended = 1;
    m_ph = nph;
  endtask

  task automatic check_all();
    chk("trc_ready", {31'd0, trc_ready}, {31'd0, m_ready()});
    chk("dct_buffer", {2'd0, dct_buffer}, m_buf_val());
    chk("dct_count", {28'd0, dct_count}, m_q.size());
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
    if (m_fv) begin
      chk("frame_data", {2'd0, frame_data}, m_frame_val());
      chk("frame_count", {28'd0, frame_count}, m_f.size());
    end
    chk("test_ending", {31'd0, test_ending}, {31'd0, m_ending});
    chk("test_has_ended", {31'd0, test_has_ended}, {31'd0, m_ended});
    chk("stall_cnt", {16'd0, stall_cnt}, m_stalls);
  endtask

  always @(negedge clk) check_all();

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input int c);
    trc_valid = 1'b1;
    trc_code  = 3'(c);
    tick();
    trc_valid = 1'b0;
  endtask

  task automatic do_reset();
    trc_valid   = 1'b0;
    stop_req    = 1'b0;
    frame_ready = 1'b0;
    reset_n     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int c1[10] = '{1, 2, 3, 4, 5, 6, 7, 1, 2, 3};
    int c2[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    int c3[10] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5};

    // Reset state
    do_reset();
    chk("rst dct_count", {28'd0, dct_count}, 0);
    chk("rst frame_valid", {31'd0, frame_valid}, 0);
    chk("rst trc_ready", {31'd0, trc_ready}, 1);

    // Ten accepts, immediate consume
    frame_ready = 1'b1;
    foreach (c1[i]) send(c1[i]);
    chk("t1 full buffer", {2'd0, dct_buffer}, 32'(30'o1234567123));
    chk("t1 full count", {28'd0, dct_count}, 10);
    tick();
    chk("t1 frame_valid", {31'd0, frame_valid}, 1);
    chk("t1 frame_data", {2'd0, frame_data}, 32'(30'o1234567123));
    chk("t1 frame_count", {28'd0, frame_count}, 10);
    chk("t1 count cleared", {28'd0, dct_count}, 0);
    tick();
    chk("t1 frame one cycle", {31'd0, frame_valid}, 0);

    // Held frame, full buffer back-pressure, accept during transfer
    frame_ready = 1'b0;
    foreach (c2[i]) send(c2[i]);
    tick();
    chk("t2 frame_data", {2'd0, frame_data}, 32'(30'o7654321076));
    foreach (c3[i]) send(c3[i]);
    chk("t2 stalled ready", {31'd0, trc_ready}, 0);
    chk("t2 stalled count", {28'd0, dct_count}, 10);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t2 consumed", {31'd0, frame_valid}, 0);
    chk("t2 ready back", {31'd0, trc_ready}, 1);
    send(5);
    chk("t2 same-cycle count", {28'd0, dct_count}, 1);
    chk("t2 same-cycle buffer", {2'd0, dct_buffer}, 5);
    chk("t2 new frame", {2'd0, frame_data}, 32'(30'o1122334455));
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;

    // Partial flush
    do_reset();
    send(5);
    send(6);
    send(7);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    chk("t3 test_ending", {31'd0, test_ending}, 1);
    chk("t3 ready in flush", {31'd0, trc_ready}, 0);
    tick();
    chk("t3 flush frame_valid", {31'd0, frame_valid}, 1);
    chk("t3 flush data", {2'd0, frame_data}, 32'(30'o0000000567));
    chk("t3 flush count", {28'd0, frame_count}, 3);
    tick();
    chk("t3 not ended yet", {31'd0, test_has_ended}, 0);
    frame_ready = 1'b1;
    tick();
    tick();
    chk("t3 ended", {31'd0, test_has_ended}, 1);

    // Empty stop
    do_reset();
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    chk("t4 ending", {31'd0, test_ending}, 1);
    chk("t4 ended early", {31'd0, test_has_ended}, 0);
    tick();
    chk("t4 ended +1", {31'd0, test_has_ended}, 0);
    tick();
    chk("t4 ended +2", {31'd0, test_has_ended}, 1);
    chk("t4 no frame", {31'd0, frame_valid}, 0);

    // Reset during FLUSH with a pending frame
    do_reset();
    foreach (c2[i]) send(c2[i]);
    tick();
    send(1);
    send(2);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    tick();
    chk("t5 pending frame", {31'd0, frame_valid}, 1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t5 rst frame_valid", {31'd0, frame_valid}, 0);
    chk("t5 rst frame_data", {2'd0, frame_data}, 0);
    chk("t5 rst dct_count", {28'd0, dct_count}, 0);
    chk("t5 rst ending", {31'd0, test_ending}, 0);
    chk("t5 rst ready", {31'd0, trc_ready}, 1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    send(3);
    chk("t5 run after reset", {28'd0, dct_count}, 1);

    // Stall counting
    do_reset();
    foreach (c2[i]) send(c2[i]);
    tick();
    foreach (c3[i]) send(c3[i]);
    trc_valid = 1'b1;
    repeat (5) tick();
    trc_valid = 1'b0;
`ifdef DCT_STALL_COUNTER_EN
    chk("t6 stall_cnt", {16'd0, stall_cnt}, 5);
`else
    chk("t6 stall_cnt", {16'd0, stall_cnt}, 0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nios_led_cpu_oci_dct_packer.md
Name: nios_led_cpu_oci_dct_packer

Overview:
- Debug-trace capture stage feeding the OCI test bench.
- Packs 3-bit trace codes from the CPU debug logic into a 10-slot, 30-bit buffer and reports the live buffer state on dct_buffer/dct_count.
- Hands complete or partial frames downstream over a valid/ready handshake.
- Runs the end-of-test sequence: test_ending while flushing, then test_has_ended once drained.

Parameters:
- SLOT_W, 3, bits per trace code.
- SLOTS, 10, slots per frame; SLOT_W*SLOTS = 30.
- CNT_W, 4, width of the slot counters; must hold 0..SLOTS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trc_valid  in  1  trace code offered.
- trc_code  in  3  trace code.
- trc_ready  out  1  code accepted when trc_valid && trc_ready.
- stop_req  in  1  end-of-test request, level or pulse.
- dct_buffer  out  30  live packing buffer; newest code in [2:0].
- dct_count  out  4  valid slots in dct_buffer, 0..10.
- frame_valid  out  1  frame holding register full.
- frame_data  out  30  frame payload.
- frame_count  out  4  valid slots in frame_data, 1..10.
- frame_ready  in  1  downstream takes the frame when frame_valid && frame_ready.
- test_ending  out  1  flush in progress or complete.
- test_has_ended  out  1  all frames drained.
- stall_cnt  out  16  see Optional Feature.

Behaviour:
- Reset (async, reset_n=0):
  - outputs: dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, frame_count=0, test_ending=0, test_has_ended=0, stall_cnt=0.
  - state=RUN.
  - Applies mid-operation too; any pending frame is discarded.
- States: RUN, FLUSH, DRAIN, ENDED.
- trc_ready = (state==RUN) && ((dct_count<SLOTS) || !frame_valid). It has no combinational path from frame_ready.
- Accept (RUN only): dct_buffer <= {dct_buffer[26:0], trc_code}; dct_count += 1. Visible one cycle after the accept edge.
- Transfer condition: dct_count==SLOTS && !frame_valid, or a flush transfer (see FLUSH).
  - frame_data <= dct_buffer; frame_count <= dct_count; frame_valid <= 1.
  - Buffer clears to 0, count to 0.
  - If an accept happens in the same cycle: dct_buffer <= {27'b0, trc_code}, dct_count <= 1.
- Handshake: frame_valid && frame_ready clears frame_valid next cycle.
  - frame_data/frame_count hold while frame_valid=1.
  - Clear and a new transfer in the same cycle: new transfer wins; frame_valid stays 1 with the new data.
- Full buffer (dct_count==10) with frame_valid=1: trc_ready=0; buffer holds until the frame is consumed.
- RUN -> FLUSH when stop_req=1.
  - An accept in that same cycle still completes.
  - test_ending <= 1 on entering FLUSH; sticky until reset.
- FLUSH:
  - trc_ready=0.
  - If dct_count==0: go to DRAIN.
  - Otherwise wait for !frame_valid, then transfer the partial buffer as is (codes in LSBs, upper bits 0, frame_count=dct_count) and go to DRAIN.
- DRAIN: when frame_valid==0, go to ENDED.
- ENDED: test_has_ended <= 1 on entry; sticky until reset. stop_req is ignored after RUN.
- test_has_ended rises at least one cycle after test_ending.

Optional Feature:
- Macro: DCT_STALL_COUNTER_EN.
- Defined: stall_cnt increments each cycle trc_valid && !trc_ready, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: no counter logic; stall_cnt is tied to 0.

Test Plan:
- Ten accepts, codes 1..7,1,2,3, frame_ready=1 -> frame_data=30'o1234567123, frame_count=10, frame_valid one cycle, dct_count back to 0.
- Frame held with frame_ready=0, then 10 more codes -> trc_ready=0 at dct_count=10. Raise frame_ready -> old frame clears; new frame transferred next cycle; trc_ready returns to 1.
- Three codes (5,6,7), then stop_req pulse -> test_ending=1, frame_data=30'o0000000567, frame_count=3. After consume -> test_has_ended=1.
- stop_req with dct_count=0 and no frame pending -> no frame_valid; test_has_ended=1 two cycles after test_ending.
- Accept on the same cycle as a full-buffer transfer -> dct_count=1, dct_buffer=code.
- Assert reset_n=0 mid-FLUSH with frame_valid=1 -> all outputs 0 immediately, state RUN.
- With DCT_STALL_COUNTER_EN: hold trc_valid=1 for 5 stalled cycles -> stall_cnt=5.
